// File: rtl/ex_stage.sv
// Execute stage: ID/EX latch, ALU, branch/jump resolution and EX/MEM register.
// Taken control transfers raise EX_flush for FLUSH_CYCLES cycles and pulse pc_redirect.
module ex_stage #(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            id_valid,
    input  logic [3:0]      ALU_op,
    input  logic            id_is_branch,
    input  logic [XLEN-1:0] id_operand_a,
    input  logic [XLEN-1:0] id_operand_b,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_imm,
    input  logic [XLEN-1:0] id_store_data,
    input  logic [4:0]      id_rd,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_result,
    output logic [XLEN-1:0] ex_store_data,
    output logic [4:0]      ex_rd,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            EX_flush,
    output logic            pc_redirect,
    output logic [XLEN-1:0] redirect_target
);

    localparam int CW = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES);

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_LT   = 4'd5,
        OP_JUMP = 4'd6,
        OP_SLL  = 4'd7,
        OP_SRL  = 4'd8,
        OP_NOPE = 4'd9
    } alu_op_e;

    typedef struct packed {
        logic            valid;
        logic [3:0]      op;
        logic            br;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] sd;
        logic [4:0]      rd;
        logic            rw;
        logic            mr;
        logic            mw;
    } lat_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] res;
        logic [XLEN-1:0] sd;
        logic [4:0]      rd;
        logic            rw;
        logic            mr;
        logic            mw;
    } exm_t;

    lat_t            lat_q, lat_d, bubble;
    exm_t            exm_q, exm_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] res;
    logic            op_def;
    logic            is_jump;
    logic            taken;
    logic            flush;

    // ALU on latched operands; undefined encodings fall into the bubble path
    always_comb begin
        res    = '0;
        op_def = 1'b1;
        unique case (lat_q.op)
            OP_ADD:  res = lat_q.a + lat_q.b;
            OP_SUB:  res = lat_q.a - lat_q.b;
            OP_AND:  res = lat_q.a & lat_q.b;
            OP_OR:   res = lat_q.a | lat_q.b;
            OP_XOR:  res = lat_q.a ^ lat_q.b;
            OP_LT:   res = {{(XLEN-1){1'b0}},
                            $signed(lat_q.a) < $signed(lat_q.b)};
            OP_JUMP: res = lat_q.pc + XLEN'(4);
            OP_SLL:  res = lat_q.a << lat_q.b[4:0];
            OP_SRL:  res = lat_q.a >> lat_q.b[4:0];
            default: op_def = 1'b0;
        endcase
    end

    always_comb begin
        is_jump = lat_q.op == OP_JUMP;
        taken   = lat_q.valid & ~stall &
                  (is_jump |
                   (lat_q.br &
                    (((lat_q.op == OP_SUB) & (res == '0)) |
                     ((lat_q.op == OP_LT) & res[0]))));
        flush   = taken | (cnt_q != '0);
    end

    always_comb begin
        cnt_d = cnt_q;
        if (taken)
            cnt_d = CW'(FLUSH_CYCLES - 1);
        else if (!stall && cnt_q != '0)
            cnt_d = cnt_q - CW'(1);
    end

    always_comb begin
        bubble    = '0;
        bubble.op = OP_NOPE;
        lat_d     = lat_q;
        if (!stall) begin
            if (flush) begin
                lat_d = bubble;
            end else begin
                lat_d.valid = id_valid;
                lat_d.op    = ALU_op;
                lat_d.br    = id_is_branch;
                lat_d.a     = id_operand_a;
                lat_d.b     = id_operand_b;
                lat_d.pc    = id_pc;
                lat_d.imm   = id_imm;
                lat_d.sd    = id_store_data;
                lat_d.rd    = id_rd;
                lat_d.rw    = id_reg_write;
                lat_d.mr    = id_mem_read;
                lat_d.mw    = id_mem_write;
            end
        end
    end

    // Conditional branches keep their slot but never write anything back
    always_comb begin
        logic live;
        live  = lat_q.valid & op_def;
        exm_d = exm_q;
        if (!stall) begin
            exm_d.valid = live;
            exm_d.res   = res;
            exm_d.sd    = live ? lat_q.sd : '0;
            exm_d.rd    = live ? lat_q.rd : '0;
            exm_d.rw    = live & lat_q.rw & ~lat_q.br;
            exm_d.mr    = live & lat_q.mr & ~lat_q.br;
            exm_d.mw    = live & lat_q.mw & ~lat_q.br;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lat_q    <= '0;
            lat_q.op <= OP_NOPE;
            exm_q    <= '0;
            cnt_q    <= '0;
        end else begin
            lat_q <= lat_d;
            exm_q <= exm_d;
            cnt_q <= cnt_d;
        end
    end

    assign ex_valid        = exm_q.valid;
    assign ex_result       = exm_q.res;
    assign ex_store_data   = exm_q.sd;
    assign ex_rd           = exm_q.rd;
    assign ex_reg_write    = exm_q.rw;
    assign ex_mem_read     = exm_q.mr;
    assign ex_mem_write    = exm_q.mw;
    assign EX_flush        = flush;
    assign pc_redirect     = taken;
    assign redirect_target = lat_q.pc + lat_q.imm;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU ops, branch/jump redirect, flush window,
// stall deferral and reset during a flush.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        id_valid;
    logic [3:0]  ALU_op;
    logic        id_is_branch;
    logic [31:0] id_operand_a;
    logic [31:0] id_operand_b;
    logic [31:0] id_pc;
    logic [31:0] id_imm;
    logic [31:0] id_store_data;
    logic [4:0]  id_rd;
    logic        id_reg_write;
    logic        id_mem_read;
    logic        id_mem_write;
    logic        ex_valid;
    logic [31:0] ex_result;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        EX_flush;
    logic        pc_redirect;
    logic [31:0] redirect_target;

    int checks = 0;
    int errors = 0;
    int pulses;

    always #5 clk = ~clk;

    ex_stage #(.XLEN(32), .FLUSH_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .id_valid(id_valid), .ALU_op(ALU_op),
        .id_is_branch(id_is_branch),
        .id_operand_a(id_operand_a), .id_operand_b(id_operand_b),
        .id_pc(id_pc), .id_imm(id_imm),
        .id_store_data(id_store_data), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write),
        .ex_valid(ex_valid), .ex_result(ex_result),
        .ex_store_data(ex_store_data), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write),
        .EX_flush(EX_flush), .pc_redirect(pc_redirect),
        .redirect_target(redirect_target)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid      = 1'b0;
        ALU_op        = 4'd9;
        id_is_branch  = 1'b0;
        id_operand_a  = '0;
        id_operand_b  = '0;
        id_pc         = '0;
        id_imm        = '0;
        id_store_data = '0;
        id_rd         = '0;
        id_reg_write  = 1'b0;
        id_mem_read   = 1'b0;
        id_mem_write  = 1'b0;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic br,
                         input logic [31:0] pc, input logic [31:0] imm,
                         input logic [4:0] rd, input logic rw);
        idle();
        id_valid     = 1'b1;
        ALU_op       = op;
        id_is_branch = br;
        id_operand_a = a;
        id_operand_b = b;
        id_pc        = pc;
        id_imm       = imm;
        id_rd        = rd;
        id_reg_write = rw;
    endtask

    // issue one ALU op, push a bubble behind it, check its EX/MEM result
    task automatic alu(input string tag, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp);
        issue(op, a, b, 1'b0, '0, '0, 5'd4, 1'b1);
        step();
        idle();
        step();
        chk(tag, ex_result, exp);
    endtask

    initial begin
        rst   = 1'b1;
        stall = 1'b0;
        idle();
        step();
        step();
        rst = 1'b0;
        step();
        chk("rst_valid", ex_valid, 0);
        chk("rst_result", ex_result, 0);
        chk("rst_rw", ex_reg_write, 0);
        chk("rst_flush", EX_flush, 0);
        chk("rst_redir", pc_redirect, 0);

        stall = 1'b1;
        issue(4'd0, 32'd1, 32'd1, 1'b0, '0, '0, 5'd2, 1'b1);
        step();
        step();
        chk("stall_bub_rw", ex_reg_write, 0);
        chk("stall_bub_valid", ex_valid, 0);
        idle();
        stall = 1'b0;
        step();
        step();

        issue(4'd0, 32'd5, 32'd7, 1'b0, '0, '0, 5'd3, 1'b1);
        step();
        idle();
        step();
        chk("add_res", ex_result, 32'd12);
        chk("add_rd", ex_rd, 5'd3);
        chk("add_rw", ex_reg_write, 1);
        chk("add_valid", ex_valid, 1);

        alu("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'd1, 32'h0);
        alu("lt", 4'd5, 32'hFFFF_FFF0, 32'd1, 32'h1);
        alu("srl", 4'd8, 32'hFFFF_FFF0, 32'd4, 32'h0FFF_FFFF);
        alu("sll", 4'd7, 32'hFFFF_FFF0, 32'd36, 32'hFFFF_FF00);
        alu("sub", 4'd1, 32'hFFFF_FFF0, 32'h10, 32'hFFFF_FFE0);
        alu("xor", 4'd4, 32'hF0F0_1234, 32'h0FF0_1234, 32'hFF00_0000);
        alu("undef", 4'd12, 32'h5, 32'h5, 32'h0);
        chk("undef_rw", ex_reg_write, 0);

        issue(4'd0, 32'h1000, 32'd8, 1'b0, '0, '0, 5'd0, 1'b0);
        id_mem_write  = 1'b1;
        id_store_data = 32'hCAFE;
        step();
        idle();
        step();
        chk("st_addr", ex_result, 32'h1008);
        chk("st_mw", ex_mem_write, 1);
        chk("st_data", ex_store_data, 32'hCAFE);

        issue(4'd1, 32'd9, 32'd9, 1'b1, 32'h100, 32'h20, 5'd5, 1'b1);
        step();
        issue(4'd0, 32'd1, 32'd1, 1'b0, '0, '0, 5'd6, 1'b1);
        #1;
        chk("beq_redir", pc_redirect, 1);
        chk("beq_target", redirect_target, 32'h120);
        chk("beq_flush0", EX_flush, 1);
        step();
        chk("beq_slot_valid", ex_valid, 1);
        chk("beq_slot_rw", ex_reg_write, 0);
        chk("beq_redir_once", pc_redirect, 0);
        chk("beq_flush1", EX_flush, 1);
        issue(4'd0, 32'd1, 32'd2, 1'b0, '0, '0, 5'd7, 1'b1);
        step();
        chk("beq_flush_end", EX_flush, 0);
        chk("sq1_valid", ex_valid, 0);
        chk("sq1_rw", ex_reg_write, 0);
        issue(4'd0, 32'd2, 32'd3, 1'b0, '0, '0, 5'd8, 1'b1);
        step();
        chk("sq2_valid", ex_valid, 0);
        chk("sq2_rw", ex_reg_write, 0);
        idle();
        step();
        chk("post_res", ex_result, 32'd5);
        chk("post_rd", ex_rd, 5'd8);
        chk("post_rw", ex_reg_write, 1);

        issue(4'd5, 32'd3, 32'hFFFF_FFFF, 1'b1, 32'h80, 32'h10, 5'd1, 1'b1);
        step();
        chk("blt_redir", pc_redirect, 0);
        chk("blt_flush", EX_flush, 0);
        idle();
        step();
        chk("blt_rw", ex_reg_write, 0);
        chk("blt_valid", ex_valid, 1);

        issue(4'd6, '0, '0, 1'b0, 32'h40, 32'hFFFF_FFF8, 5'd1, 1'b1);
        step();
        chk("jal_redir", pc_redirect, 1);
        chk("jal_target", redirect_target, 32'h38);
        idle();
        step();
        chk("jal_link", ex_result, 32'h44);
        chk("jal_rw", ex_reg_write, 1);
        chk("jal_rd", ex_rd, 5'd1);
        step();
        step();

        issue(4'd1, 32'd4, 32'd4, 1'b1, 32'h200, 32'h10, 5'd2, 1'b0);
        step();
        stall = 1'b1;
        issue(4'd0, 32'd1, 32'd1, 1'b0, '0, '0, 5'd9, 1'b1);
        pulses = 0;
        #1;
        for (int i = 0; i < 3; i++) begin
            if (pc_redirect) pulses++;
            chk("stl_flush", EX_flush, 0);
            chk("stl_hold", ex_valid, 0);
            step();
        end
        chk("stl_pulses", pulses, 0);
        stall = 1'b0;
        #1;
        chk("rel_redir", pc_redirect, 1);
        chk("rel_target", redirect_target, 32'h210);
        step();
        chk("rel_once", pc_redirect, 0);
        chk("rel_slot", ex_valid, 1);
        chk("mid_flush", EX_flush, 1);

        rst = 1'b1;
        step();
        rst = 1'b0;
        idle();
        #1;
        chk("rst_mid_flush", EX_flush, 0);
        chk("rst_mid_valid", ex_valid, 0);
        step();
        chk("rst_after", EX_flush, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
